scalar_mul_sequencer: RTL

//  Left-to-right double-and-add controller for ECC scalar multiplication Q = k*P.

---
 rtl/scalar_mul_if.sv | 44 ++++
 rtl/scalar_mul_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mul_if.sv
// ============================================================================
// Module      : scalar_mul_if
// Description : Command/status and engine handshake bundle for the ECC
//               double-and-add scalar multiplication sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scalar_mul_if #(
  parameter int KEY_W  = 576,
  parameter int ADDR_W = 6,
  parameter int IDX_W  = 10
);
  logic              start;
  logic [KEY_W-1:0]  scalar;
  logic              irq_double;
  logic              irq_add;
  logic              irq_transfer;
  logic [1:0]        command_add_double;
  logic              cmd_transfer;
  logic              read_write_command;
  logic [ADDR_W-1:0] read_address;
  logic [ADDR_W-1:0] write_address;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;
  logic [IDX_W-1:0]  bit_index;

  // Sequencer side: takes commands and engine interrupts, drives everything else.
  modport slave (
    input  start, scalar, irq_double, irq_add, irq_transfer,
    output command_add_double, cmd_transfer, read_write_command,
           read_address, write_address, busy, done, err_code, bit_index
  );

  // Environment side: host command plus point engine and RAM transfer unit.
  modport master (
    output start, scalar, irq_double, irq_add, irq_transfer,
    input  command_add_double, cmd_transfer, read_write_command,
           read_address, write_address, busy, done, err_code, bit_index
  );
endinterface

`default_nettype wire

// File: rtl/scalar_mul_sequencer.sv
// ============================================================================
// Module      : scalar_mul_sequencer
// Description : Left-to-right double-and-add controller computing Q = k*P.
//               Loads P into the accumulator, walks the key MSB->LSB issuing
//               point-double / point-add commands, then stores the result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scalar_mul_sequencer #(
  parameter int                KEY_W  = 576,
  parameter int                ADDR_W = 6,
  parameter int                IDX_W  = 10,
  parameter logic [ADDR_W-1:0] ADDR_P = 6'h04,
  parameter logic [ADDR_W-1:0] ADDR_Q = 6'h08,
  parameter logic [ADDR_W-1:0] ADDR_R = 6'h0C,
  parameter logic [15:0]       TMO    = 16'hFFFF
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  scalar_mul_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SCAN  = 4'd1,
    S_LOAD  = 4'd2,
    S_W_LD  = 4'd3,
    S_NEXT  = 4'd4,
    S_DBL   = 4'd5,
    S_W_DBL = 4'd6,
    S_ADD   = 4'd7,
    S_W_ADD = 4'd8,
    S_STORE = 4'd9,
    S_W_ST  = 4'd10,
    S_FIN   = 4'd11
  } state_t;

  localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(KEY_W - 1);
  localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);
  // Wait is abandoned here so that done lands exactly TMO cycles after the
  // command pulse: the FIN cycle and the registered done take the last two.
  localparam logic [15:0]      c_tmo_last = TMO - 16'd2;

  state_t            r_state,   w_state_n;
  logic [KEY_W-1:0]  r_k,       w_k_n;
  logic [IDX_W-1:0]  r_idx,     w_idx_n;
  logic [15:0]       r_tmo,     w_tmo_n;
  logic [1:0]        r_cmd,     w_cmd_n;
  logic              r_xfer,    w_xfer_n;
  logic              r_rw,      w_rw_n;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_n;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_n;
  logic              r_busy,    w_busy_n;
  logic              r_done,    w_done_n;
  logic [1:0]        r_err,     w_err_n;

  logic w_bit;
  logic w_irq_ok;
  logic w_tmo_hit;

  assign w_bit     = r_k[r_idx];
  // The cycle carrying a command pulse never accepts its own interrupt.
  assign w_irq_ok  = !(r_xfer || (r_cmd != 2'b00));
  assign w_tmo_hit = (r_tmo == c_tmo_last);

  // State and output register bank; every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_cmd     <= 2'b00;
      r_xfer    <= 1'b0;
      r_rw      <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 2'b00;
    end else begin
      r_state   <= w_state_n;
      r_k       <= w_k_n;
      r_idx     <= w_idx_n;
      r_tmo     <= w_tmo_n;
      r_cmd     <= w_cmd_n;
      r_xfer    <= w_xfer_n;
      r_rw      <= w_rw_n;
      r_rd_addr <= w_rd_addr_n;
      r_wr_addr <= w_wr_addr_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
    end
  end

  // Next-state and next-output decode for the double-and-add walk.
  always_comb begin
    w_state_n   = r_state;
    w_k_n       = r_k;
    w_idx_n     = r_idx;
    w_tmo_n     = r_tmo;
    w_cmd_n     = 2'b00;
    w_xfer_n    = 1'b0;
    w_rw_n      = r_rw;
    w_rd_addr_n = r_rd_addr;
    w_wr_addr_n = r_wr_addr;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_err_n     = r_err;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_k_n     = bus.scalar;
          w_idx_n   = c_idx_top;
          w_err_n   = 2'b00;
          w_busy_n  = 1'b1;
          w_state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_bit) begin
          w_state_n = S_LOAD;
        end else if (r_idx != '0) begin
          w_idx_n = r_idx - c_idx_one;
        end else begin
          w_err_n   = 2'b01;
          w_state_n = S_FIN;
        end
      end
      S_LOAD: begin
        w_xfer_n    = 1'b1;
        w_rw_n      = 1'b1;
        w_rd_addr_n = ADDR_P;
        w_wr_addr_n = ADDR_Q;
        w_tmo_n     = '0;
        w_state_n   = S_W_LD;
      end
      S_NEXT: begin
        if (r_idx == '0) begin
          w_state_n = S_STORE;
        end else begin
          w_idx_n   = r_idx - c_idx_one;
          w_state_n = S_DBL;
        end
      end
      S_DBL: begin
        w_cmd_n   = 2'b01;
        w_tmo_n   = '0;
        w_state_n = S_W_DBL;
      end
      S_ADD: begin
        w_cmd_n   = 2'b10;
        w_tmo_n   = '0;
        w_state_n = S_W_ADD;
      end
      S_STORE: begin
        w_xfer_n    = 1'b1;
        w_rw_n      = 1'b0;
        w_rd_addr_n = ADDR_Q;
        w_wr_addr_n = ADDR_R;
        w_tmo_n     = '0;
        w_state_n   = S_W_ST;
      end
      S_W_LD, S_W_DBL, S_W_ADD, S_W_ST: begin
        w_tmo_n = r_tmo + 16'd1;
        if (w_irq_ok && (r_state == S_W_LD) && bus.irq_transfer) begin
          w_state_n = S_NEXT;
        end else if (w_irq_ok && (r_state == S_W_DBL) && bus.irq_double) begin
          w_state_n = w_bit ? S_ADD : S_NEXT;
        end else if (w_irq_ok && (r_state == S_W_ADD) && bus.irq_add) begin
          w_state_n = S_NEXT;
        end else if (w_irq_ok && (r_state == S_W_ST) && bus.irq_transfer) begin
          w_state_n = S_FIN;
        end else if (w_tmo_hit) begin
          w_err_n   = 2'b10;
          w_state_n = S_FIN;
        end
      end
      S_FIN: begin
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign bus.command_add_double = r_cmd;
  assign bus.cmd_transfer       = r_xfer;
  assign bus.read_write_command = r_rw;
  assign bus.read_address       = r_rd_addr;
  assign bus.write_address      = r_wr_addr;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.err_code           = r_err;
  assign bus.bit_index          = r_idx;

endmodule

`default_nettype wire
